// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared parameters and state type for the filter-bank channel serializer
package fb_pkg;
   localparam int NUM_CH   = 16;
   localparam int IN_W     = 33;
   localparam int IN_FRAC  = 32;
   localparam int OUT_W    = 16;
   localparam int OUT_FRAC = 15;
   localparam int SH       = IN_FRAC - OUT_FRAC;
   localparam int CH_W     = $clog2(NUM_CH);

   typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/fb_round_sat.sv
// rtl/fb_round_sat.sv - combinational sfix33_En32 -> sfix16_En15 round and saturate
// Define FB_CONVERGENT_ROUND_EN for round-half-to-even instead of round-half-up.
module fb_round_sat
   import fb_pkg::*;
(
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);
   localparam int QW = IN_W + 1 - SH;
   localparam logic [IN_W:0]  BIAS = (IN_W+1)'(1) << (SH - 1);
   localparam logic [SH-1:0]  TIE  = (SH)'(1) << (SH - 1);

   logic [IN_W:0] ext;
   logic [IN_W:0] sum;
   logic [QW-1:0] q;
   logic          add_bias;
   logic          pos_ovf;
   logic          neg_ovf;

`ifdef FB_CONVERGENT_ROUND_EN
   // Exact ties with an even kept LSB round down; everything else is half-up.
   assign add_bias = !((din[SH-1:0] == TIE) && !din[SH]);
`else
   assign add_bias = 1'b1;
`endif

   // One guard bit above the sign keeps the biased sum from wrapping.
   assign ext = {din[IN_W-1], din};
   assign sum = ext + (add_bias ? BIAS : '0);
   assign q   = sum[IN_W:SH];

   assign pos_ovf = !q[QW-1] && (q[QW-2:OUT_W-1] != '0);
   assign neg_ovf =  q[QW-1] && (q[QW-2:OUT_W-1] != '1);

   always_comb begin
      dout = q[OUT_W-1:0];
      sat  = 1'b0;
      if (pos_ovf) begin
         dout = {1'b0, {(OUT_W-1){1'b1}}};
         sat  = 1'b1;
      end else if (neg_ovf) begin
         dout = {1'b1, {(OUT_W-1){1'b0}}};
         sat  = 1'b1;
      end
   end
endmodule

// File: rtl/fb_channel_serializer.sv
// rtl/fb_channel_serializer.sv - captures a filter-bank frame and streams one channel per cycle
// Rounding mode follows FB_CONVERGENT_ROUND_EN inside fb_round_sat.
module fb_channel_serializer
   import fb_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clk_enable,
   input  logic                   frame_valid,
   input  logic [NUM_CH*IN_W-1:0] ch_in,
   output logic [OUT_W-1:0]       out_data,
   output logic [CH_W-1:0]        out_ch,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   out_sat,
   output logic                   frame_drop
);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   state_t                 state;
   logic [CH_W-1:0]        ch;
   logic [NUM_CH*IN_W-1:0] active_bank;
   logic [NUM_CH*IN_W-1:0] pending_bank;
   logic                   pending_full;
   logic [IN_W-1:0]        cur_word;
   logic                   xfer;
   logic                   last_xfer;

   assign out_valid = (state == STREAM);
   assign out_ch    = ch;
   assign out_last  = out_valid && (ch == LAST_CH);
   assign xfer      = out_valid && out_ready;
   assign last_xfer = xfer && (ch == LAST_CH);
   assign cur_word  = active_bank[ch*IN_W +: IN_W];

   fb_round_sat u_round_sat (
      .din  (cur_word),
      .dout (out_data),
      .sat  (out_sat)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         ch           <= '0;
         active_bank  <= '0;
         pending_bank <= '0;
         pending_full <= 1'b0;
         frame_drop   <= 1'b0;
      end else if (clk_enable) begin
         frame_drop <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_valid) begin
                  active_bank <= ch_in;
                  ch          <= '0;
                  state       <= STREAM;
               end
            end
            STREAM: begin
               if (last_xfer) begin
                  ch <= '0;
                  // Frame boundary: promote pending (if any) so the stream has no bubble.
                  if (pending_full) begin
                     active_bank <= pending_bank;
                     if (frame_valid)
                        pending_bank <= ch_in;
                     else
                        pending_full <= 1'b0;
                  end else if (frame_valid) begin
                     active_bank <= ch_in;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  if (xfer)
                     ch <= ch + 1'b1;
                  if (frame_valid) begin
                     pending_bank <= ch_in;
                     pending_full <= 1'b1;
                     frame_drop   <= pending_full;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_channel_serializer.sv
// tb/tb_fb_channel_serializer.sv - directed self-checking bench for fb_channel_serializer
module tb_fb_channel_serializer;
   import fb_pkg::*;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   clk_enable;
   logic                   frame_valid;
   logic [NUM_CH*IN_W-1:0] ch_in;
   logic [OUT_W-1:0]       out_data;
   logic [CH_W-1:0]        out_ch;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   logic                   out_sat;
   logic                   frame_drop;

   int n_pass = 0;
   int n_total = 0;

   fb_channel_serializer dut (
      .clock       (clock),
      .reset       (reset),
      .clk_enable  (clk_enable),
      .frame_valid (frame_valid),
      .ch_in       (ch_in),
      .out_data    (out_data),
      .out_ch      (out_ch),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .out_sat     (out_sat),
      .frame_drop  (frame_drop)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [IN_W-1:0]  din;
      logic [OUT_W-1:0] exp_data;
      logic             exp_sat;
   } rvec_t;

   rvec_t rtab[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic send_frame(input logic [NUM_CH*IN_W-1:0] f);
      ch_in       = f;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
   endtask

   function automatic logic [NUM_CH*IN_W-1:0] ramp(input int base);
      logic [NUM_CH*IN_W-1:0] f;
      f = '0;
      for (int k = 0; k < NUM_CH; k++)
         f[k*IN_W +: IN_W] = IN_W'(base + k) << SH;
      return f;
   endfunction

   // Checks the current word, then advances one clock (caller keeps out_ready=1).
   task automatic expect_word(input string tag, input int k, input int data);
      chk({tag, " valid"}, 64'(out_valid), 64'd1);
      chk({tag, " ch"},    64'(out_ch),    64'(k));
      chk({tag, " data"},  64'(out_data),  64'(data));
      chk({tag, " last"},  64'(out_last),  64'(k == NUM_CH - 1));
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      logic [NUM_CH*IN_W-1:0] f;
      int guard;

      reset = 1'b0; clk_enable = 1'b1; frame_valid = 1'b0; ch_in = '0; out_ready = 1'b1;
      @(negedge clock);
      do_reset();
      chk("reset valid", 64'(out_valid), 64'd0);
      chk("reset ch",    64'(out_ch),    64'd0);
      chk("reset last",  64'(out_last),  64'd0);
      chk("reset sat",   64'(out_sat),   64'd0);
      chk("reset drop",  64'(frame_drop),64'd0);
      chk("reset data",  64'(out_data),  64'd0);

      // Single frame, ramp
      send_frame(ramp(0));
      for (int k = 0; k < NUM_CH; k++) expect_word("ramp", k, k);
      chk("ramp idle", 64'(out_valid), 64'd0);

      // Rounding/saturation table
      rtab[0] = '{33'h0_0001_0000, 16'h0001, 1'b0};
      rtab[1] = '{33'h0_0003_0000, 16'h0002, 1'b0};
      rtab[2] = '{33'h1_FFFF_0000, 16'h0000, 1'b0};
      rtab[3] = '{33'h0_FFFF_FFFF, 16'h7FFF, 1'b1};
      rtab[4] = '{33'h1_0000_0000, 16'h8000, 1'b0};
      rtab[5] = '{33'h0_FFFE_FFFF, 16'h7FFF, 1'b0};
      rtab[6] = '{33'h0_0000_FFFF, 16'h0000, 1'b0};
      rtab[7] = '{33'h1_FFFE_FFFF, 16'hFFFF, 1'b0};
      rtab[8] = '{33'h0_0005_0000, 16'h0003, 1'b0};
      rtab[9] = '{33'h1_FFFD_0000, 16'hFFFF, 1'b0};
`ifdef FB_CONVERGENT_ROUND_EN
      rtab[0].exp_data = 16'h0000;
      rtab[8].exp_data = 16'h0002;
      rtab[9].exp_data = 16'hFFFE;
`endif
      f = '0;
      for (int i = 0; i < 10; i++) f[i*IN_W +: IN_W] = rtab[i].din;
      send_frame(f);
      for (int i = 0; i < NUM_CH; i++) begin
         chk($sformatf("round%0d data", i), 64'(out_data), (i < 10) ? 64'(rtab[i].exp_data) : 64'd0);
         chk($sformatf("round%0d sat", i),  64'(out_sat),  (i < 10) ? 64'(rtab[i].exp_sat)  : 64'd0);
         tick();
      end
      chk("round idle", 64'(out_valid), 64'd0);

      // Backpressure at ch 7
      send_frame(ramp(0));
      for (int k = 0; k < 7; k++) expect_word("bp pre", k, k);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("bp hold ch",   64'(out_ch),   64'd7);
         chk("bp hold data", 64'(out_data), 64'd7);
         chk("bp hold valid",64'(out_valid),64'd1);
         tick();
      end
      out_ready = 1'b1;
      for (int k = 7; k < NUM_CH; k++) expect_word("bp post", k, k);
      chk("bp idle", 64'(out_valid), 64'd0);

      // Pending/drop: A streams stalled, B pends, C overwrites B
      out_ready = 1'b0;
      send_frame(ramp(0));
      chk("drop after A", 64'(frame_drop), 64'd0);
      send_frame(ramp(200));
      chk("drop after B", 64'(frame_drop), 64'd0);
      send_frame(ramp(100));
      chk("drop after C", 64'(frame_drop), 64'd1);
      tick();
      chk("drop pulse end", 64'(frame_drop), 64'd0);
      out_ready = 1'b1;
      for (int k = 0; k < NUM_CH; k++) expect_word("frame A", k, k);
      for (int k = 0; k < NUM_CH; k++) expect_word("frame C", k, 100 + k);
      chk("AC idle", 64'(out_valid), 64'd0);

      // Frame strobed exactly on the last transfer with pending empty
      send_frame(ramp(0));
      for (int k = 0; k < NUM_CH - 1; k++) expect_word("edge A", k, k);
      ch_in = ramp(50); frame_valid = 1'b1;
      expect_word("edge A", NUM_CH - 1, NUM_CH - 1);
      frame_valid = 1'b0;
      for (int k = 0; k < NUM_CH; k++) expect_word("edge next", k, 50 + k);
      chk("edge idle", 64'(out_valid), 64'd0);

      // Reset mid-stream at ch 5
      send_frame(ramp(0));
      for (int k = 0; k < 5; k++) expect_word("rst pre", k, k);
      do_reset();
      chk("rst valid", 64'(out_valid), 64'd0);
      chk("rst ch",    64'(out_ch),    64'd0);
      chk("rst data",  64'(out_data),  64'd0);
      send_frame(ramp(100));
      for (int k = 0; k < NUM_CH; k++) expect_word("rst next", k, 100 + k);
      chk("rst idle", 64'(out_valid), 64'd0);

      // clk_enable low for 3 cycles at ch 3, with an ignored strobe
      send_frame(ramp(0));
      for (int k = 0; k < 3; k++) expect_word("en pre", k, k);
      clk_enable = 1'b0;
      ch_in = ramp(200);
      for (int c = 0; c < 3; c++) begin
         frame_valid = (c == 1);
         chk("en hold ch",   64'(out_ch),   64'd3);
         chk("en hold data", 64'(out_data), 64'd3);
         chk("en hold valid",64'(out_valid),64'd1);
         tick();
      end
      frame_valid = 1'b0;
      clk_enable = 1'b1;
      for (int k = 3; k < NUM_CH; k++) expect_word("en post", k, k);
      guard = 0;
      chk("en idle", 64'(out_valid), 64'd0);
      while (out_valid && guard < 40) begin
         tick();
         guard++;
      end
      chk("en no ghost frame", 64'(guard), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
